// File: rtl/pipe_latch_skid_if.sv
// Handshake/data bundle for one pipe_latch_skid stage boundary.
//   slave  : the latch side (consumes pc_in/ir_in, presents pc_out/ir_out)
//   master : the surrounding stages (upstream producer + downstream consumer)
// Signals:
//   in_valid/in_ready/pc_in/ir_in      upstream handshake and payload
//   flush                              drop held entries and current input
//   out_valid/out_ready/pc_out/ir_out  downstream handshake and payload
//   occupancy                          held entries, 0..2
//   stall_count                        saturating back-pressure edge count
interface pipe_latch_skid_if #(
    parameter int PC_WIDTH  = 32,
    parameter int IR_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PC_WIDTH-1:0]  pc_in;
    logic [IR_WIDTH-1:0]  ir_in;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [PC_WIDTH-1:0]  pc_out;
    logic [IR_WIDTH-1:0]  ir_out;
    logic [1:0]           occupancy;
    logic [CNT_WIDTH-1:0] stall_count;

    modport slave (
        input  in_valid, pc_in, ir_in, flush, out_ready,
        output in_ready, out_valid, pc_out, ir_out, occupancy, stall_count
    );

    modport master (
        output in_valid, pc_in, ir_in, flush, out_ready,
        input  in_ready, out_valid, pc_out, ir_out, occupancy, stall_count
    );
endinterface

// File: rtl/pipe_latch_skid.sv
// Pipeline-stage latch for a PC/instruction pair with a two-entry skid
// buffer. All state changes on the falling edge of clk; reset is
// asynchronous active-high. in_ready and out_valid come from registered
// state only, so out_ready/flush never reach them combinationally.
// Ports:
//   clk    stage clock (falling-edge active)
//   reset  asynchronous active-high clear
//   bus    pipe_latch_skid_if.slave (handshakes, payload, flush, status)
module pipe_latch_skid #(
    parameter int                PC_WIDTH  = 32,
    parameter int                IR_WIDTH  = 32,
    parameter logic [IR_WIDTH-1:0] NOP_IR  = {IR_WIDTH{1'b0}},
    parameter int                CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_latch_skid_if.slave bus
);
    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t               state, state_nxt;
    logic [PC_WIDTH-1:0]  head_pc, skid_pc;
    logic [IR_WIDTH-1:0]  head_ir, skid_ir;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic                 accept, drain;
    logic                 load_head_in, load_head_skid, load_skid;

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = bus.out_valid & bus.out_ready;

    // State register
    always_ff @(negedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Next state and datapath load selects
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nxt    = ONE;
                    load_head_in = 1'b1;
                end
                ONE: begin
                    if (accept && drain) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: if (drain) begin
                    state_nxt      = ONE;
                    load_head_skid = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Outputs: payload masked by registered valid so stale data never leaks
    always_comb begin
        bus.in_ready    = (state != FULL);
        bus.out_valid   = (state != EMPTY);
        bus.pc_out      = bus.out_valid ? head_pc : '0;
        bus.ir_out      = bus.out_valid ? head_ir : NOP_IR;
        bus.occupancy   = state;
        bus.stall_count = stall_cnt;
    end

    // Head/skid payload registers
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            head_pc <= '0;
            head_ir <= '0;
            skid_pc <= '0;
            skid_ir <= '0;
        end else begin
            if (load_head_in) begin
                head_pc <= bus.pc_in;
                head_ir <= bus.ir_in;
            end else if (load_head_skid) begin
                head_pc <= skid_pc;
                head_ir <= skid_ir;
            end
            if (load_skid) begin
                skid_pc <= bus.pc_in;
                skid_ir <= bus.ir_in;
            end
        end
    end

    // Saturating stall counter; the flush edge counts too
    always_ff @(negedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (bus.out_valid && !bus.out_ready && (stall_cnt != {CNT_WIDTH{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_latch_skid.sv
// Bench for pipe_latch_skid: two instances (32/32 with a 4-bit counter and
// 16/24 with a non-zero NOP) share one stimulus stream. A queue-level model
// of the latch predicts outputs; directed phases pin it with literals.
module tb_pipe_latch_skid;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_latch_skid_if #(.PC_WIDTH(32), .IR_WIDTH(32), .CNT_WIDTH(4))  bus_a ();
    pipe_latch_skid_if #(.PC_WIDTH(16), .IR_WIDTH(24), .CNT_WIDTH(16)) bus_b ();

    pipe_latch_skid #(.PC_WIDTH(32), .IR_WIDTH(32), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    pipe_latch_skid #(.PC_WIDTH(16), .IR_WIDTH(24), .NOP_IR(24'h000013), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    // Shared stimulus, fanned to both instances (B gets the low bits)
    logic        in_valid, out_ready, flush;
    logic [31:0] pc_in, ir_in;
    always_comb begin
        bus_a.in_valid = in_valid; bus_a.out_ready = out_ready; bus_a.flush = flush;
        bus_a.pc_in = pc_in;       bus_a.ir_in = ir_in;
        bus_b.in_valid = in_valid; bus_b.out_ready = out_ready; bus_b.flush = flush;
        bus_b.pc_in = pc_in[15:0]; bus_b.ir_in = ir_in[23:0];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an ordered list of held entries plus a stall tally
    typedef struct { logic [31:0] pc; logic [31:0] ir; } entry_t;
    entry_t q[$];
    int     stalls = 0;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            stalls = 0;
        end else begin
            int  n;
            bit  take, give;
            n    = q.size();
            take = in_valid && (n < 2);
            give = (n > 0) && out_ready;
            if (n > 0 && !out_ready) stalls++;
            if (flush) q.delete();
            else begin
                if (give) void'(q.pop_front());
                if (take) q.push_back('{pc: pc_in, ir: ir_in});
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(posedge clk) begin
        if (!reset) begin
            bit          v;
            logic [31:0] epc, eir;
            v   = (q.size() != 0);
            epc = v ? q[0].pc : 32'h0;
            eir = v ? q[0].ir : 32'h0;
            check("a_out_valid", bus_a.out_valid, v);
            check("a_in_ready",  bus_a.in_ready, q.size() < 2);
            check("a_occupancy", bus_a.occupancy, q.size());
            check("a_pc_out",    bus_a.pc_out, epc);
            check("a_ir_out",    bus_a.ir_out, eir);
            check("a_stall",     bus_a.stall_count, (stalls > 15) ? 15 : stalls);
            check("b_out_valid", bus_b.out_valid, v);
            check("b_occupancy", bus_b.occupancy, q.size());
            check("b_pc_out",    bus_b.pc_out, epc[15:0]);
            check("b_ir_out",    bus_b.ir_out, v ? {8'h0, eir[23:0]} : 64'h13);
            check("b_stall",     bus_b.stall_count, (stalls > 65535) ? 65535 : stalls);
        end
    end

    // One falling edge passes between consecutive calls; inputs settle mid-high phase
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic drive(input bit v, input bit r, input bit f, input logic [31:0] pc);
        in_valid = v; out_ready = r; flush = f; pc_in = pc; ir_in = ~pc;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 32'h0);
        step();
        check("rst_occ",      bus_a.occupancy, 0);
        check("rst_valid",    bus_a.out_valid, 0);
        check("rst_ready",    bus_a.in_ready, 1);
        check("rst_pc",       bus_a.pc_out, 0);
        check("rst_ir_a",     bus_a.ir_out, 0);
        check("rst_ir_b_nop", bus_b.ir_out, 24'h000013);
        check("rst_stall",    bus_a.stall_count, 0);
        reset = 1'b0;

        // Streaming at full rate
        drive(1, 1, 0, 32'h100); step();
        check("stream_pc0", bus_a.pc_out, 32'h100);
        check("stream_vld", bus_a.out_valid, 1);
        drive(1, 1, 0, 32'h104); step();
        check("stream_pc1", bus_a.pc_out, 32'h104);
        drive(1, 1, 0, 32'h108); step();
        check("stream_pc2", bus_a.pc_out, 32'h108);
        check("stream_occ", bus_a.occupancy, 1);
        check("stream_stall", bus_a.stall_count, 0);
        drive(0, 1, 0, 32'h0); step();
        check("stream_drained", bus_a.occupancy, 0);

        // Back-pressure into the skid entry
        drive(1, 0, 0, 32'h200); step();
        check("bp_head", bus_a.pc_out, 32'h200);
        drive(1, 0, 0, 32'h204); step();
        check("bp_occ2",  bus_a.occupancy, 2);
        check("bp_rdy0",  bus_a.in_ready, 0);
        check("bp_pc",    bus_a.pc_out, 32'h200);
        check("bp_stall1", bus_a.stall_count, 1);
        drive(0, 0, 0, 32'h0); step();
        check("bp_stall2", bus_a.stall_count, 2);
        drive(0, 1, 0, 32'h0); step();
        check("bp_next", bus_a.pc_out, 32'h204);
        check("bp_occ1", bus_a.occupancy, 1);
        step();
        check("bp_empty", bus_a.occupancy, 0);

        // Flush while FULL with a live input
        drive(1, 0, 0, 32'h2f0); step();
        drive(1, 0, 0, 32'h2f4); step();
        check("fl_full", bus_a.occupancy, 2);
        drive(1, 0, 1, 32'h300); step();
        check("fl_occ",   bus_a.occupancy, 0);
        check("fl_valid", bus_a.out_valid, 0);
        check("fl_pc",    bus_a.pc_out, 0);
        check("fl_ir_b",  bus_b.ir_out, 24'h000013);
        check("fl_rdy",   bus_a.in_ready, 1);
        check("fl_stall", bus_a.stall_count, 4);
        drive(0, 1, 0, 32'h0); step();
        check("fl_no300", bus_a.out_valid, 0);

        // Saturation of the 4-bit counter
        drive(1, 0, 0, 32'h500);
        repeat (20) step();
        check("sat_15", bus_a.stall_count, 15);
        step();
        check("sat_hold", bus_a.stall_count, 15);
        check("sat_b", bus_b.stall_count, 24);

        // Asynchronous reset between edges while FULL
        #1 reset = 1'b1;
        #1;
        check("arst_occ",   bus_a.occupancy, 0);
        check("arst_valid", bus_a.out_valid, 0);
        check("arst_pc",    bus_a.pc_out, 0);
        check("arst_rdy",   bus_a.in_ready, 1);
        check("arst_stall", bus_a.stall_count, 0);
        check("arst_ir_b",  bus_b.ir_out, 24'h000013);
        reset = 1'b0;
        drive(1, 0, 0, 32'h400); step();
        check("arst_first", bus_a.pc_out, 32'h400);
        check("arst_alone", bus_a.occupancy, 1);
        drive(0, 1, 0, 32'h0); step();
        check("arst_drain", bus_a.occupancy, 0);

        // Randomised traffic with occasional flush and mid-cycle reset
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            pc_in     = $urandom;
            ir_in     = $urandom;
            if ($urandom_range(0, 300) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
